// File: rtl/merge_out_packer_pkg.sv
// Shared constants and state encoding for the merge output packer.
// Edit the widths here; the interface, FIFO and top all derive from them.
package merge_out_packer_pkg;

   localparam int DATA_WIDTH = 128;
   localparam int LINE_WIDTH = 512;
   localparam int ADDR_WIDTH = 64;
   localparam int LEN_WIDTH  = 32;
   localparam int OBUF_DEPTH = 4;

   localparam int BPL        = LINE_WIDTH / (2 * DATA_WIDTH);
   localparam int LINE_BYTES = LINE_WIDTH / 8;

   // Max key, so padded slots keep the output sorted.
   localparam logic [2*DATA_WIDTH-1:0] PAD_RECORD = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DRAIN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/merge_out_packer_if.sv
// Beat input, line write port and pass control of the merge output packer.
interface merge_out_packer_if;
   import merge_out_packer_pkg::*;

   // Beat in: taken when i_valid & o_ready. Line out: taken when o_wr_valid & i_wr_ready;
   // o_wr_addr/o_wr_data hold steady while o_wr_valid is high and i_wr_ready is low.
   logic                    i_start;
   logic [ADDR_WIDTH-1:0]   i_base_addr;
   logic [LEN_WIDTH-1:0]    i_num_beats;
   logic                    i_valid;
   logic [2*DATA_WIDTH-1:0] i_data;
   logic                    o_ready;
   logic                    o_wr_valid;
   logic [ADDR_WIDTH-1:0]   o_wr_addr;
   logic [LINE_WIDTH-1:0]   o_wr_data;
   logic                    i_wr_ready;
   logic                    o_busy;
   logic                    o_done;
   logic                    o_err;

   modport master (
      output i_start, i_base_addr, i_num_beats, i_valid, i_data, i_wr_ready,
      input  o_ready, o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_done, o_err
   );

   modport slave (
      input  i_start, i_base_addr, i_num_beats, i_valid, i_data, i_wr_ready,
      output o_ready, o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_done, o_err
   );

endinterface

// File: rtl/merge_out_packer_line_fifo.sv
// First-word-fall-through synchronous FIFO holding {address, line} write requests.
module merge_out_packer_line_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Extra pointer bit tells full from empty when the indices match.
   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_push && !o_full) begin
         mem_d[wr_ptr_q[AW-1:0]] = i_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (i_pop && !o_empty) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/merge_out_packer.sv
// Packs sorted two-record beats into memory lines, pads the last line with max keys
// and writes the lines sequentially from a programmed base address.
module merge_out_packer
   import merge_out_packer_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   merge_out_packer_if.slave   bus,
   output state_e              o_dbg_state
);

   localparam int BW       = 2 * DATA_WIDTH;
   localparam int FW       = LINE_WIDTH + ADDR_WIDTH;
   localparam int SLOT_W   = (BPL > 1) ? $clog2(BPL) : 1;
   localparam int LAST_LSB = (BPL - 1) * BW;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BPL - 1);

   state_e                state_q, state_d;
   logic [LEN_WIDTH-1:0]  num_q, num_d;
   logic [LEN_WIDTH-1:0]  beat_q, beat_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [LINE_WIDTH-1:0] asm_q, asm_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  err_q, err_d;

   logic                  ready;
   logic                  accept;
   logic                  push;
   logic [LINE_WIDTH-1:0] push_line;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FW-1:0]         fifo_dout;

   assign ready  = (state_q == ST_RUN) && !fifo_full;
   assign accept = bus.i_valid && ready;
   assign pop    = !fifo_empty && bus.i_wr_ready;

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      beat_d    = beat_q;
      slot_d    = slot_q;
      asm_d     = asm_q;
      addr_d    = addr_q;
      err_d     = err_q;
      push      = 1'b0;
      push_line = asm_q;
      if (bus.i_valid && !ready) err_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               num_d   = bus.i_num_beats;
               addr_d  = bus.i_base_addr;
               beat_d  = '0;
               slot_d  = '0;
               asm_d   = {BPL{PAD_RECORD}};
               err_d   = 1'b0;
               state_d = (bus.i_num_beats == '0) ? ST_FLUSH : ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               beat_d = beat_q + LEN_WIDTH'(1);
               if (slot_q == LAST_SLOT) begin
                  // Completing beat goes straight into the pushed line, not via asm_q.
                  push                          = 1'b1;
                  push_line[LAST_LSB +: BW]     = bus.i_data;
                  slot_d                        = '0;
                  asm_d                         = {BPL{PAD_RECORD}};
                  addr_d                        = addr_q + ADDR_WIDTH'(LINE_BYTES);
               end else begin
                  asm_d[int'(slot_q) * BW +: BW] = bus.i_data;
                  slot_d                         = slot_q + 1'b1;
               end
               if (beat_q + LEN_WIDTH'(1) == num_q) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (slot_q == '0) begin
               state_d = ST_DRAIN;
            end else if (!fifo_full) begin
               push    = 1'b1;
               slot_d  = '0;
               asm_d   = {BPL{PAD_RECORD}};
               addr_d  = addr_q + ADDR_WIDTH'(LINE_BYTES);
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         num_q   <= '0;
         beat_q  <= '0;
         slot_q  <= '0;
         asm_q   <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         beat_q  <= beat_d;
         slot_q  <= slot_d;
         asm_q   <= asm_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   merge_out_packer_line_fifo #(
      .WIDTH (FW),
      .DEPTH (OBUF_DEPTH)
   ) u_line_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_data  ({addr_q, push_line}),
      .i_pop   (pop),
      .o_data  (fifo_dout),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   assign bus.o_ready    = ready;
   assign bus.o_wr_valid = !fifo_empty;
   assign bus.o_wr_addr  = fifo_dout[FW-1 -: ADDR_WIDTH];
   assign bus.o_wr_data  = fifo_dout[LINE_WIDTH-1:0];
   assign bus.o_busy     = (state_q != ST_IDLE);
   assign bus.o_done     = (state_q == ST_DONE);
   assign bus.o_err      = err_q;
   assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_merge_out_packer.sv
// Bench for merge_out_packer: directed corner passes plus random passes, with every
// written line checked against lines built from the beats that were sent.
module tb_merge_out_packer;
   import merge_out_packer_pkg::*;

   localparam int BW = 2 * DATA_WIDTH;
   localparam int CW = LINE_WIDTH;

   logic   clk = 1'b0;
   logic   rst;
   state_e dbg_state;

   always #5 clk = ~clk;

   merge_out_packer_if bus();

   merge_out_packer dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   int acc_cnt  = 0;
   int wr_mode  = 0;

   logic [LINE_WIDTH-1:0] exp_q[$];
   logic [ADDR_WIDTH-1:0] exp_addr_q[$];
   logic [BW-1:0]         beat_mem [64];

   logic                  hold = 1'b0;
   logic [LINE_WIDTH-1:0] held_data;
   logic [ADDR_WIDTH-1:0] held_addr;
   logic [ADDR_WIDTH-1:0] last_addr = '0;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: beats grouped BPL per line, low slot first, gaps filled with all-ones.
   task automatic model_pass(input logic [ADDR_WIDTH-1:0] base, input int num);
      logic [LINE_WIDTH-1:0] line;
      int n_lines;
      n_lines = (num + BPL - 1) / BPL;
      for (int n = 0; n < n_lines; n++) begin
         line = '1;
         for (int k = 0; k < BPL; k++) begin
            if (n * BPL + k < num) line[k * BW +: BW] = beat_mem[n * BPL + k];
         end
         exp_q.push_back(line);
         exp_addr_q.push_back(base + ADDR_WIDTH'(n) * ADDR_WIDTH'(LINE_BYTES));
      end
   endtask

   task automatic fill_seq(input int n);
      for (int i = 0; i < n; i++) beat_mem[i] = BW'(i + 1);
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++)
         for (int w = 0; w < BW / 32; w++) beat_mem[i][w * 32 +: 32] = $urandom;
   endtask

   always begin
      @(posedge clk);
      #1;
      case (wr_mode)
         0:       bus.i_wr_ready = 1'b1;
         1:       bus.i_wr_ready = 1'($urandom_range(0, 1));
         default: bus.i_wr_ready = 1'b0;
      endcase
   end

   // Write-port scoreboard and stall-stability monitor.
   always @(negedge clk) begin
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (bus.o_done) done_cnt++;
         if (bus.o_wr_valid && hold) begin
            check("stall_data", bus.o_wr_data, held_data);
            check("stall_addr", CW'(bus.o_wr_addr), CW'(held_addr));
         end
         if (bus.o_wr_valid && bus.i_wr_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_wr", 1'b1, 1'b0);
            end else begin
               check("wr_data", bus.o_wr_data, exp_q.pop_front());
               check("wr_addr", CW'(bus.o_wr_addr), CW'(exp_addr_q.pop_front()));
            end
            wr_cnt++;
            last_addr = bus.o_wr_addr;
            hold      = 1'b0;
         end else if (bus.o_wr_valid) begin
            hold      = 1'b1;
            held_data = bus.o_wr_data;
            held_addr = bus.o_wr_addr;
         end else begin
            hold = 1'b0;
         end
      end
   end

   task automatic start_pass(input logic [ADDR_WIDTH-1:0] base, input int num);
      @(negedge clk);
      done_cnt        = 0;
      bus.i_start     = 1'b1;
      bus.i_base_addr = base;
      bus.i_num_beats = LEN_WIDTH'(num);
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
   endtask

   task automatic send_one(input int idx);
      int budget;
      budget = 0;
      @(negedge clk);
      while (!bus.o_ready && budget < 400) begin
         @(negedge clk);
         budget++;
      end
      if (!bus.o_ready) begin
         check("ready_timeout", 1'b0, 1'b1);
         return;
      end
      bus.i_valid = 1'b1;
      bus.i_data  = beat_mem[idx];
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      acc_cnt++;
   endtask

   task automatic send_beats(input int num, input int max_gap);
      for (int i = 0; i < num; i++) begin
         send_one(i);
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
      end
   endtask

   task automatic wait_done(input logic exp_err);
      int   budget;
      logic seen;
      budget = 0;
      seen   = 1'b0;
      while (!seen && budget < 2000) begin
         @(negedge clk);
         seen = bus.o_done;
         budget++;
      end
      check("done_seen", seen, 1'b1);
      repeat (2) @(negedge clk);
      check("done_once", CW'(done_cnt), CW'(1));
      check("lines_left", CW'(exp_q.size()), CW'(0));
      check("err_flag", bus.o_err, exp_err);
      check("idle_after", bus.o_busy, 1'b0);
   endtask

   initial begin
      int wr0;
      int num;
      logic [ADDR_WIDTH-1:0] base;

      rst             = 1'b1;
      bus.i_start     = 1'b0;
      bus.i_base_addr = '0;
      bus.i_num_beats = '0;
      bus.i_valid     = 1'b0;
      bus.i_data      = '0;
      bus.i_wr_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready", bus.o_ready, 1'b0);
      check("rst_wr_valid", bus.o_wr_valid, 1'b0);
      check("rst_busy", bus.o_busy, 1'b0);
      check("rst_done", bus.o_done, 1'b0);
      check("rst_err", bus.o_err, 1'b0);
      check("rst_state", CW'(dbg_state), CW'(ST_IDLE));

      // Exact two lines, back-to-back beats, line visible one cycle after completion.
      wr_mode = 0;
      repeat (2) @(posedge clk);
      fill_seq(4);
      model_pass(64'h1000, 4);
      start_pass(64'h1000, 4);
      check("busy_run", bus.o_busy, 1'b1);
      send_one(0);
      check("no_line_half", bus.o_wr_valid, 1'b0);
      send_one(1);
      check("line_latency", bus.o_wr_valid, 1'b1);
      send_one(2);
      send_one(3);
      wait_done(1'b0);

      // Partial last line padded with all-ones.
      fill_seq(3);
      model_pass(64'h2000, 3);
      start_pass(64'h2000, 3);
      send_beats(3, 2);
      wait_done(1'b0);

      // Empty pass: no writes, done two cycles after the start edge.
      wr0 = wr_cnt;
      start_pass(64'h3000, 0);
      check("zero_done_early", bus.o_done, 1'b0);
      @(posedge clk);
      #1;
      check("zero_done_early2", bus.o_done, 1'b0);
      @(posedge clk);
      #1;
      check("zero_done", bus.o_done, 1'b1);
      repeat (3) @(negedge clk);
      check("zero_no_wr", CW'(wr_cnt - wr0), CW'(0));

      // Stalled write port: buffer fills to OBUF_DEPTH lines and input stalls.
      wr_mode = 2;
      repeat (2) @(posedge clk);
      fill_random(16);
      model_pass(64'h10000, 16);
      wr0     = wr_cnt;
      acc_cnt = 0;
      start_pass(64'h10000, 16);
      fork
         send_beats(16, 0);
         begin
            repeat (20) @(posedge clk);
            #2;
            check("full_accepted", CW'(acc_cnt), CW'(OBUF_DEPTH * BPL));
            check("full_ready", bus.o_ready, 1'b0);
            check("full_wr_valid", bus.o_wr_valid, 1'b1);
            check("full_state", CW'(dbg_state), CW'(ST_RUN));
            wr_mode = 0;
         end
      join
      wait_done(1'b0);
      check("full_wr_count", CW'(wr_cnt - wr0), CW'(8));

      // Beat offered while not ready: sticky error, beat not taken.
      wr_mode = 2;
      repeat (2) @(posedge clk);
      fill_random(4);
      model_pass(64'h20000, 4);
      start_pass(64'h20000, 4);
      send_beats(4, 0);
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_data  = '1;
      repeat (3) @(posedge clk);
      #1;
      check("err_set", bus.o_err, 1'b1);
      check("err_not_ready", bus.o_ready, 1'b0);
      bus.i_valid = 1'b0;
      wr_mode     = 0;
      wait_done(1'b1);

      // Address wrap; the new start also clears the error flag.
      base = 64'hFFFF_FFFF_FFFF_FFC0;
      fill_random(4);
      model_pass(base, 4);
      start_pass(base, 4);
      check("err_cleared", bus.o_err, 1'b0);
      send_beats(4, 1);
      wait_done(1'b0);
      check("wrap_addr", CW'(last_addr), CW'(0));

      // Reset mid-pass with two lines buffered: everything pending is discarded.
      wr_mode = 2;
      repeat (2) @(posedge clk);
      fill_random(8);
      start_pass(64'h4000, 8);
      for (int i = 0; i < 4; i++) send_one(i);
      @(negedge clk);
      check("pre_rst_wr_valid", bus.o_wr_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_wr_valid", bus.o_wr_valid, 1'b0);
      check("rst_mid_busy", bus.o_busy, 1'b0);
      @(negedge clk);
      #2;
      rst     = 1'b0;
      wr_mode = 0;
      repeat (2) @(posedge clk);
      fill_random(2);
      model_pass(64'h8000, 2);
      start_pass(64'h8000, 2);
      send_beats(2, 1);
      wait_done(1'b0);
      check("post_rst_addr", CW'(last_addr), CW'(64'h8000));

      // Random passes under random write backpressure.
      wr_mode = 1;
      for (int p = 0; p < 6; p++) begin
         num  = $urandom_range(1, 13);
         base = {$urandom, $urandom} & ~64'(LINE_BYTES - 1);
         fill_random(num);
         model_pass(base, num);
         start_pass(base, num);
         send_beats(num, 2);
         wait_done(1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
